alk_sio_seq: RTL and testbench

Parametrised, sequenced successor to the ALK ALU shift-in/out routing for the DC615 datapath slice. It holds a local shift register and runs multi-step shifts and rotates (SHL, SHR, ROL, ROR, ASR) of STEP_W bits per clock. Each step drives the fill bits onto the open-drain ALU_SIO pads at the entry end of the word and takes the new bits back from the wire-ANDed pad inputs. Adjacent slices or external logic can therefore inject or override shift-in bits. A start/busy/done handshake and step counter sequence the operation.

---
 rtl/alk_sio_seq.sv | 129 ++++++++++++
 tb/tb_alk_sio_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alk_sio_seq.sv
// Sequenced shift/rotate register for the DC615 slice. Shift-in bits travel
// through the open-drain ALU_SIO pads so neighbouring logic can override them.
module alk_sio_seq #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 1,
    parameter int CNT_W  = 5
) (
    input  logic              clk_h,
    input  logic              reset_h,
    input  logic              start_h,
    input  logic [2:0]        op_h,
    input  logic [CNT_W-1:0]  count_h,
    input  logic              load_h,
    input  logic [DATA_W-1:0] data_in_h,
    input  logic [STEP_W-1:0] sin_h,
    input  logic [STEP_W-1:0] alu_sio_lsb_in_l,
    input  logic [STEP_W-1:0] alu_sio_msb_in_l,
    output logic [STEP_W-1:0] alu_sio_lsb_out_l,
    output logic [STEP_W-1:0] alu_sio_msb_out_l,
    output logic [DATA_W-1:0] q_h,
    output logic [STEP_W-1:0] sout_h,
    output logic              busy_h,
    output logic              done_h
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_r;
    logic [DATA_W-1:0] q;
    logic [STEP_W-1:0] sout;
    logic [STEP_W-1:0] fill;
    logic              left_op;
    logic              imm_done;

    // A zero count or an illegal opcode completes without touching q.
    assign imm_done = (count_h == '0) || (op_h > OP_ASR);
    assign left_op  = (op_r == OP_SHL) || (op_r == OP_ROL);

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_h) begin
                    state_nxt = imm_done ? DONE : SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fill = sin_h;
        case (op_r)
            OP_ROL:  fill = q[DATA_W-1 -: STEP_W];
            OP_ROR:  fill = q[STEP_W-1:0];
            OP_ASR:  fill = {STEP_W{q[DATA_W-1]}};
            default: fill = sin_h;
        endcase
        alu_sio_lsb_out_l = '1;
        alu_sio_msb_out_l = '1;
        if (state == SHIFT) begin
            if (left_op) begin
                alu_sio_lsb_out_l = ~fill;
            end else begin
                alu_sio_msb_out_l = ~fill;
            end
        end
    end

    // New bits come back from the wire-ANDed pad receivers, not from fill.
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            cnt  <= '0;
            op_r <= OP_SHL;
            q    <= '0;
            sout <= '0;
        end else if (state == SHIFT) begin
            cnt <= cnt - CNT_W'(1);
            if (left_op) begin
                q    <= {q[DATA_W-STEP_W-1:0], ~alu_sio_lsb_in_l};
                sout <= q[DATA_W-1 -: STEP_W];
            end else begin
                q    <= {~alu_sio_msb_in_l, q[DATA_W-1:STEP_W]};
                sout <= q[STEP_W-1:0];
            end
        end else begin
            if (load_h) begin
                q <= data_in_h;
            end
            if (start_h) begin
                op_r <= op_h;
                cnt  <= count_h;
            end
        end
    end

    assign q_h    = q;
    assign sout_h = sout;
    assign busy_h = (state == SHIFT);
    assign done_h = (state == DONE);

endmodule

// File: tb/tb_alk_sio_seq.sv
// Bench for alk_sio_seq: a 1-bit-step and a 4-bit-step slice, each with its
// pads wire-ANDed against bench-controlled external pulls.
module tb_alk_sio_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // slice 0: STEP_W=1
    logic        start0, load0;
    logic [2:0]  op0;
    logic [4:0]  cnt0;
    logic [31:0] data0, q0;
    logic [0:0]  sin0, extl0, extm0, lsb_out0, msb_out0, lsb_in0, msb_in0, sout0;
    logic        busy0, done0;
    assign lsb_in0 = lsb_out0 & extl0;
    assign msb_in0 = msb_out0 & extm0;

    // slice 1: STEP_W=4
    logic        start1, load1;
    logic [2:0]  op1;
    logic [4:0]  cnt1;
    logic [31:0] data1, q1;
    logic [3:0]  sin1, extl1, extm1, lsb_out1, msb_out1, lsb_in1, msb_in1, sout1;
    logic        busy1, done1;
    assign lsb_in1 = lsb_out1 & extl1;
    assign msb_in1 = msb_out1 & extm1;

    alk_sio_seq #(.DATA_W(32), .STEP_W(1), .CNT_W(5)) dut0 (
        .clk_h(clk), .reset_h(reset), .start_h(start0), .op_h(op0), .count_h(cnt0),
        .load_h(load0), .data_in_h(data0), .sin_h(sin0),
        .alu_sio_lsb_in_l(lsb_in0), .alu_sio_msb_in_l(msb_in0),
        .alu_sio_lsb_out_l(lsb_out0), .alu_sio_msb_out_l(msb_out0),
        .q_h(q0), .sout_h(sout0), .busy_h(busy0), .done_h(done0)
    );

    alk_sio_seq #(.DATA_W(32), .STEP_W(4), .CNT_W(5)) dut1 (
        .clk_h(clk), .reset_h(reset), .start_h(start1), .op_h(op1), .count_h(cnt1),
        .load_h(load1), .data_in_h(data1), .sin_h(sin1),
        .alu_sio_lsb_in_l(lsb_in1), .alu_sio_msb_in_l(msb_in1),
        .alu_sio_lsb_out_l(lsb_out1), .alu_sio_msb_out_l(msb_out1),
        .q_h(q1), .sout_h(sout1), .busy_h(busy1), .done_h(done1)
    );

    // Reference model state per slice.
    logic [31:0] mq[2];
    logic [3:0]  msout[2];
    logic [3:0]  cur_sin[2], cur_extl[2], cur_extm[2];
    int          sw[2] = '{1, 4};

    typedef struct packed {
        logic [31:0] q;
        logic [3:0]  sout;
        logic [3:0]  lsb;
        logic [3:0]  msb;
        logic        busy;
        logic        done;
    } obs_t;

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.q = q0; o.sout = {3'b000, sout0}; o.lsb = {3'b000, lsb_out0};
            o.msb = {3'b000, msb_out0}; o.busy = busy0; o.done = done0;
        end else begin
            o.q = q1; o.sout = sout1; o.lsb = lsb_out1;
            o.msb = msb_out1; o.busy = busy1; o.done = done1;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int sel, input string tag, input logic eb, input logic ed,
                             input logic [3:0] el, input logic [3:0] em);
        obs_t o = get_obs(sel);
        chk($sformatf("%s%0d_q", tag, sel), o.q, mq[sel]);
        chk($sformatf("%s%0d_sout", tag, sel), {28'd0, o.sout}, {28'd0, msout[sel]});
        chk($sformatf("%s%0d_lsb_pad", tag, sel), {28'd0, o.lsb}, {28'd0, el});
        chk($sformatf("%s%0d_msb_pad", tag, sel), {28'd0, o.msb}, {28'd0, em});
        chk($sformatf("%s%0d_busy", tag, sel), {31'd0, o.busy}, {31'd0, eb});
        chk($sformatf("%s%0d_done", tag, sel), {31'd0, o.done}, {31'd0, ed});
    endtask

    task automatic drive(input int sel, input logic st, input logic ld, input logic [2:0] op,
                         input logic [4:0] c, input logic [31:0] d);
        if (sel == 0) begin
            start0 = st; load0 = ld; op0 = op; cnt0 = c; data0 = d;
        end else begin
            start1 = st; load1 = ld; op1 = op; cnt1 = c; data1 = d;
        end
    endtask

    task automatic drive_pads(input int sel, input logic [3:0] s, input logic [3:0] el,
                              input logic [3:0] em);
        cur_sin[sel] = s; cur_extl[sel] = el; cur_extm[sel] = em;
        if (sel == 0) begin
            sin0 = s[0:0]; extl0 = el[0:0]; extm0 = em[0:0];
        end else begin
            sin1 = s; extl1 = el; extm1 = em;
        end
    endtask

    function automatic logic [3:0] mask_of(input int sel);
        logic [31:0] m = (32'd1 << sw[sel]) - 32'd1;
        return m[3:0];
    endfunction

    // Bits the block puts on the wire for one step of op.
    function automatic logic [3:0] fill_of(input int sel, input logic [2:0] op);
        int          s   = sw[sel];
        logic [31:0] top = mq[sel] >> (32 - s);
        logic [3:0]  m   = mask_of(sel);
        case (op)
            3'd2:       return top[3:0] & m;
            3'd3:       return mq[sel][3:0] & m;
            3'd4:       return mq[sel][31] ? m : 4'h0;
            default:    return cur_sin[sel] & m;
        endcase
    endfunction

    task automatic apply_step(input int sel, input logic [2:0] op);
        int          s    = sw[sel];
        logic [3:0]  m    = mask_of(sel);
        logic        left = (op == 3'd0) || (op == 3'd2);
        logic [3:0]  ext  = left ? cur_extl[sel] : cur_extm[sel];
        logic [3:0]  nb4  = (fill_of(sel, op) | ~ext) & m;
        logic [31:0] nb   = {28'd0, nb4};
        logic [31:0] top  = mq[sel] >> (32 - s);
        if (left) begin
            msout[sel] = top[3:0] & m;
            mq[sel]    = (mq[sel] << s) | nb;
        end else begin
            msout[sel] = mq[sel][3:0] & m;
            mq[sel]    = (mq[sel] >> s) | (nb << (32 - s));
        end
    endtask

    // Starts an operation now (caller sits between edges, so a call right
    // after another op lands in its DONE cycle) and returns at the negedge
    // of the completion cycle.
    task automatic run_op(input int sel, input logic [2:0] op, input int n, input logic ld,
                          input logic [31:0] d, input logic rand_sin, input logic noise,
                          input string tag);
        logic [3:0] m4   = mask_of(sel);
        logic       left = (op == 3'd0) || (op == 3'd2);
        logic       imm  = (n == 0) || (op > 3'd4);
        logic [3:0] f;
        drive(sel, 1'b1, ld, op, n[4:0], d);
        if (ld) mq[sel] = d;
        @(posedge clk); #1;
        if (!imm) begin
            for (int k = 0; k < n; k++) begin
                if (noise) drive(sel, 1'($urandom), 1'($urandom), 3'($urandom), 5'($urandom), $urandom);
                else drive(sel, 1'b0, 1'b0, op, n[4:0], d);
                if (rand_sin) drive_pads(sel, 4'($urandom), cur_extl[sel], cur_extm[sel]);
                @(negedge clk);
                f = fill_of(sel, op);
                check_all(sel, {tag, "_step"}, 1'b1, 1'b0,
                          left ? (~f & m4) : m4, left ? m4 : (~f & m4));
                apply_step(sel, op);
                @(posedge clk); #1;
            end
        end
        drive(sel, 1'b0, 1'b0, op, n[4:0], d);
        @(negedge clk);
        check_all(sel, {tag, "_done"}, 1'b0, 1'b1, m4, m4);
    endtask

    task automatic idle_gap(input int sel);
        @(posedge clk); #1;
        @(negedge clk);
        check_all(sel, "idle", 1'b0, 1'b0, mask_of(sel), mask_of(sel));
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            drive(s, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
            drive_pads(s, 4'h0, 4'hF, 4'hF);
            mq[s] = 32'd0;
            msout[s] = 4'h0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all(0, "reset", 1'b0, 1'b0, 4'h1, 4'h1);
        check_all(1, "reset", 1'b0, 1'b0, 4'hF, 4'hF);

        // SHL by one through the pad loopback.
        run_op(0, 3'd0, 1, 1'b1, 32'h80000001, 1'b0, 1'b0, "shl");
        chk("shl_q_const", q0, 32'h00000002);
        chk("shl_sout_const", {31'd0, sout0}, 32'd1);

        run_op(0, 3'd3, 4, 1'b1, 32'h12345678, 1'b0, 1'b0, "ror");
        chk("ror_q_const", q0, 32'h81234567);

        run_op(0, 3'd4, 3, 1'b1, 32'h80000000, 1'b0, 1'b0, "asr");
        chk("asr_q_const", q0, 32'hF0000000);

        // External pull on the MSB-end receiver injects ones.
        drive_pads(0, 4'h0, 4'hF, 4'h0);
        run_op(0, 3'd1, 2, 1'b1, 32'h00000000, 1'b0, 1'b0, "shr_inj");
        chk("shr_inj_q_const", q0, 32'hC0000000);
        drive_pads(0, 4'h0, 4'hF, 4'hF);

        run_op(0, 3'd0, 0, 1'b0, 32'h11111111, 1'b0, 1'b0, "cnt0");
        chk("cnt0_q_const", q0, 32'hC0000000);
        run_op(0, 3'd6, 5, 1'b0, 32'h22222222, 1'b0, 1'b0, "illegal");
        chk("illegal_q_const", q0, 32'hC0000000);
        run_op(0, 3'd1, 0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, "cnt0_load");
        chk("cnt0_load_q_const", q0, 32'hDEADBEEF);

        // start/load toggling while busy must not disturb the operation.
        run_op(0, 3'd2, 6, 1'b1, 32'h0F0F00F1, 1'b1, 1'b1, "rol_noise");
        idle_gap(0);

        run_op(1, 3'd2, 2, 1'b1, 32'h12345678, 1'b0, 1'b0, "rol4");
        chk("rol4_q_const", q1, 32'h34567812);

        // Reset in the middle of a long shift.
        drive(0, 1'b1, 1'b1, 3'd0, 5'd10, 32'hA5A5A5A5);
        drive_pads(0, 4'h1, 4'hF, 4'hF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'd0, 5'd10, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mq[s] = 32'd0;
            msout[s] = 4'h0;
        end
        @(negedge clk);
        check_all(0, "midreset", 1'b0, 1'b0, 4'h1, 4'h1);
        check_all(1, "midreset", 1'b0, 1'b0, 4'hF, 4'hF);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midreset_no_done", {31'd0, done0}, 32'd0);
            chk("midreset_no_busy", {31'd0, busy0}, 32'd0);
        end

        // Randomized operations, mixing back-to-back and idle-separated starts.
        for (int sel = 0; sel < 2; sel++) begin
            for (int it = 0; it < 30; it++) begin
                logic [2:0] rop;
                int         rn;
                rop = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(5, 7))
                                                  : 3'($urandom_range(0, 4));
                rn = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 9));
                if ($urandom_range(0, 3) == 0)
                    drive_pads(sel, 4'($urandom), 4'($urandom), 4'($urandom));
                else
                    drive_pads(sel, 4'($urandom), 4'hF, 4'hF);
                run_op(sel, rop, rn, 1'($urandom), $urandom, 1'b1, 1'($urandom), "rand");
                if ($urandom_range(0, 1) == 1) idle_gap(sel);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
